// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access and register write-back stage.
// Loads and stores go over a req/ack port; the stage stalls fetch/decode
// while an access is in flight. Non-memory instructions pass straight through.
// Optional feature macro: MEM_TIMEOUT_EN (abort a REQ after TIMEOUT cycles
// with no ack, raise sticky mem_err).
module mem_wb_stage #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] st_data,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic          rf_we_in,
    input  logic [3:0]    rf_dst_in,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          wb_en,
    output logic [3:0]    wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          stall,
    output logic          mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] load_q;
    logic          aborted;   // current DONE came from a timeout, not an ack
    logic          mem_op;

    assign mem_op = mem_re | mem_we;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;
    logic          abort_q;
    logic          err_q;

    assign aborted = abort_q;
    assign mem_err = err_q;

    // Count REQ cycles; abort once TIMEOUT of them pass without an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt  <= '0;
                    abort_q <= 1'b0;
                end
                REQ: begin
                    if (!mem_ack) begin
                        if (to_cnt == CW'(TIMEOUT - 1)) begin
                            abort_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                default: to_cnt <= '0;
            endcase
        end
    end

    wire to_fire = (state == REQ) && !mem_ack && (to_cnt == CW'(TIMEOUT - 1));
`else
    // No timeout: REQ waits forever. The TIMEOUT comparison folds to 0 and
    // only keeps the parameter referenced in this build.
    assign aborted = (TIMEOUT < 0);
    assign mem_err = 1'b0;
    wire to_fire = 1'b0;
`endif

    // Main FSM plus registered memory-port outputs and load register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem_addr  <= ex_result;
                        mem_wdata <= st_data;
                        mem_wr    <= mem_we;   // re+we together acts as store
                        mem_req   <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_wr) load_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (to_fire) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;   // inputs not sampled: no retrigger
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_dst = rf_dst_in;

    // Write-back / stall mux; the IDLE non-memory path is fully combinational.
    always_comb begin
        wb_en   = 1'b0;
        wb_data = ex_result;
        stall   = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    stall = mem_op;
                    wb_en = rf_we_in & ~mem_op;
                end
                REQ: stall = 1'b1;
                DONE: begin
                    if (aborted) begin
                        wb_data = '0;
                    end else if (!mem_wr) begin
                        wb_en   = rf_we_in;
                        wb_data = load_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
